// File: rtl/button_pkg.sv
// Shared types and 50 MHz timing defaults for the push-button step front end.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } rpt_state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  function automatic int unsigned cycles_from_ms(input int unsigned ms,
                                                 input int unsigned clk_hz);
    return (clk_hz / 32'd1000) * ms;
  endfunction

  localparam int unsigned DEF_DEBOUNCE_CYCLES = cycles_from_ms(32'd20, CLK_HZ);
  localparam int unsigned DEF_REPEAT_DELAY    = cycles_from_ms(32'd500, CLK_HZ);
  localparam int unsigned DEF_REPEAT_PERIOD   = cycles_from_ms(32'd100, CLK_HZ);

endpackage

// File: rtl/button_debounce_channel.sv
// One push-button channel: synchroniser, debounce, press/auto-repeat FSM and a
// stretched active-low strobe for the negedge-triggered step controls.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = int'(DEF_DEBOUNCE_CYCLES),
  parameter int REPEAT_DELAY    = int'(DEF_REPEAT_DELAY),
  parameter int REPEAT_PERIOD   = int'(DEF_REPEAT_PERIOD),
  parameter int STROBE_LEN      = 4,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_step,
  output logic o_step_n
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int STR_W   = $clog2(STROBE_LEN + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [STR_W-1:0] STR_LOAD    = STR_W'(STROBE_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic                   stable_q, stable_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  rpt_state_e             state_q, state_d;
  logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
  logic [STR_W-1:0]       str_cnt_q, str_cnt_d;
  logic                   press_q, press_d;
  logic                   step_q, step_d;
  logic                   step_n_q, step_n_d;
  logic                   pressed;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_btn_n};
  assign sync    = sync_q[SYNC_STAGES-1];
  assign pressed = ~stable_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q    <= '1;
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
      state_q   <= RELEASED;
      rpt_cnt_q <= '0;
      str_cnt_q <= '0;
      press_q   <= 1'b0;
      step_q    <= 1'b0;
      step_n_q  <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      str_cnt_q <= str_cnt_d;
      press_q   <= press_d;
      step_q    <= step_d;
      step_n_q  <= step_n_d;
    end
  end

  // Stable level only follows sync after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable_q;
    if (sync != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    step_d    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
          state_d   = HELD;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d   = RELEASED;
          rpt_cnt_d = '0;
        end else if (REPEAT_EN && (rpt_cnt_q == DELAY_LAST)) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
          state_d   = REPEAT;
        end else if (REPEAT_EN) begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        // Release takes priority over a coincident repeat tick.
        if (!pressed) begin
          state_d   = RELEASED;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = RELEASED;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = ~stable_q;
    str_cnt_d = str_cnt_q;
    if (step_d) begin
      str_cnt_d = STR_LOAD;
    end else if (str_cnt_q != '0) begin
      str_cnt_d = str_cnt_q - 1'b1;
    end
    step_n_d = (str_cnt_d == '0);
  end

  a_no_retrigger: assert property (@(posedge i_clk) disable iff (!i_reset)
                                   step_d |-> (str_cnt_q == '0));

  assign o_press  = press_q;
  assign o_step   = step_q;
  assign o_step_n = step_n_q;

endmodule

// File: rtl/button_step_conditioner.sv
// Front end for the active-low board KEYs: one independent debounce/auto-repeat
// channel per button, feeding the theta/phi step logic.
module button_step_conditioner
  import button_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = int'(DEF_DEBOUNCE_CYCLES),
  parameter int               REPEAT_DELAY    = int'(DEF_REPEAT_DELAY),
  parameter int               REPEAT_PERIOD   = int'(DEF_REPEAT_PERIOD),
  parameter int               STROBE_LEN      = 4,
  parameter logic [N_BTN-1:0] REPEAT_EN       = {N_BTN{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn_n,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_step,
  output logic [N_BTN-1:0] o_step_n
);

  // Strobes must never overlap, which needs a repeat period of at least two strobes.
  if (REPEAT_PERIOD < 2 * STROBE_LEN || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 ||
      STROBE_LEN < 1) begin : g_bad_params
    $error("button_step_conditioner: illegal timing parameters");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .STROBE_LEN     (STROBE_LEN),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_chan (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn_n (i_btn_n[i]),
      .o_press (o_press[i]),
      .o_step  (o_step[i]),
      .o_step_n(o_step_n[i])
    );
  end

endmodule
